imem_prog_fetch: RTL and testbench

- Parametrised successor to the fixed 8-bit-PC / 16-bit-word instruction memory.
- Adds a program-load (write) port, a registered single-cycle-latency fetch port and a LOAD/RUN/HALT mode state machine.
- Sits between the program loader (bench or boot logic) and the CPU fetch stage.
- The CPU drives the PC onto fetch_addr and receives the instruction one cycle later.

---
 rtl/imem_prog_fetch_if.sv | 44 ++++
 rtl/imem_prog_fetch.sv | 145 ++++++++++++++
 tb/tb_imem_prog_fetch.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/imem_prog_fetch_if.sv
// Purpose: bundles the program-load and fetch handshake signals of imem_prog_fetch.
// Ports:   master = loader/CPU side (drives strobes, addresses, write data),
//          slave  = memory side (drives fetch results, load_count, halted, mode).
// Optional: IMEM_PARITY_EN adds par_inject (master->slave) and par_err (slave->master).
interface imem_prog_fetch_if #(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 16
);
  logic               prog_en;
  logic               start;
  logic               load_valid;
  logic [ADDR_W-1:0]  load_addr;
  logic [INSTR_W-1:0] load_data;
  logic [ADDR_W:0]    load_count;
  logic               fetch_req;
  logic [ADDR_W-1:0]  fetch_addr;
  logic               fetch_valid;
  logic [INSTR_W-1:0] fetch_instr;
  logic               fetch_err;
  logic               halted;
  logic [1:0]         mode;
`ifdef IMEM_PARITY_EN
  logic               par_inject;
  logic               par_err;
`endif

  modport master (
`ifdef IMEM_PARITY_EN
    output par_inject,
    input  par_err,
`endif
    output prog_en, start, load_valid, load_addr, load_data, fetch_req, fetch_addr,
    input  load_count, fetch_valid, fetch_instr, fetch_err, halted, mode
  );

  modport slave (
`ifdef IMEM_PARITY_EN
    input  par_inject,
    output par_err,
`endif
    input  prog_en, start, load_valid, load_addr, load_data, fetch_req, fetch_addr,
    output load_count, fetch_valid, fetch_instr, fetch_err, halted, mode
  );
endinterface

// File: rtl/imem_prog_fetch.sv
// Purpose: programmable instruction memory with a LOAD/RUN/HALT mode FSM; words are
//          written in LOAD and read in RUN with one cycle of fetch latency.
// Ports:   clk, rst (async, active-high) plus bus (imem_prog_fetch_if.slave):
//          prog_en/start mode control, load_* write port and load_count,
//          fetch_req/fetch_addr request, fetch_valid/fetch_instr/fetch_err response,
//          halted/mode status.
// Optional: IMEM_PARITY_EN stores an even-parity bit per word (par_inject/par_err).
module imem_prog_fetch #(
  parameter int         ADDR_W      = 8,
  parameter int         INSTR_W     = 16,
  parameter int         DEPTH       = 256,
  parameter logic [3:0] HALT_OPCODE = 4'hF
) (
  input logic            clk,
  input logic            rst,
  imem_prog_fetch_if.slave bus
);

  typedef enum logic [1:0] {
    S_LOAD = 2'b00,
    S_RUN  = 2'b01,
    S_HALT = 2'b10
  } state_t;

  localparam int              IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
`ifdef IMEM_PARITY_EN
  localparam int MEM_W = INSTR_W + 1;  // parity bit sits above the instruction word
`else
  localparam int MEM_W = INSTR_W;
`endif

  logic [MEM_W-1:0] mem [0:DEPTH-1];

  state_t state, state_nxt;

  logic             load_ok;
  logic             fetch_go;
  logic             fetch_in;
  logic [MEM_W-1:0] rd_word;
  logic             rd_par_bad;
  logic             rd_halt;
  logic [ADDR_W:0]  count_q;
  logic             valid_q;
  logic [INSTR_W-1:0] instr_q;
  logic             err_q;

  // Writes only land in LOAD and only for in-range addresses.
  assign load_ok  = (state == S_LOAD) && bus.load_valid && ({1'b0, bus.load_addr} < DEPTH_L);
  // prog_en in RUN drops the request issued in the same cycle.
  assign fetch_go = (state == S_RUN) && !bus.prog_en && bus.fetch_req;
  assign fetch_in = ({1'b0, bus.fetch_addr} < DEPTH_L);
  assign rd_word  = mem[bus.fetch_addr[IDX_W-1:0]];

`ifdef IMEM_PARITY_EN
  // Even parity over data plus stored bit: any odd XOR means the word is corrupt.
  assign rd_par_bad = ^rd_word;
`else
  assign rd_par_bad = 1'b0;
`endif

  // A corrupt word must never stop the CPU, even if its opcode looks like halt.
  assign rd_halt = fetch_in && !rd_par_bad && (rd_word[INSTR_W-1 -: 4] == HALT_OPCODE);

  // ---------------- memory array (no reset: contents survive rst) ----------------
  always_ff @(posedge clk) begin
    if (load_ok) begin
`ifdef IMEM_PARITY_EN
      mem[bus.load_addr[IDX_W-1:0]] <= {(^bus.load_data) ^ bus.par_inject, bus.load_data};
`else
      mem[bus.load_addr[IDX_W-1:0]] <= bus.load_data;
`endif
    end
  end

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_LOAD;
    else     state <= state_nxt;
  end

  // ---------------- FSM: next-state logic ----------------
  // The halt decision is taken on the read that returns the halt word, so HALT
  // is entered on the same edge that presents that word with fetch_valid.
  always_comb begin
    state_nxt = state;
    case (state)
      S_LOAD: if (bus.start) state_nxt = S_RUN;
      S_RUN: begin
        if (bus.prog_en)               state_nxt = S_LOAD;
        else if (fetch_go && rd_halt)  state_nxt = S_HALT;
      end
      S_HALT: if (bus.prog_en) state_nxt = S_LOAD;
      default: state_nxt = S_LOAD;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    bus.halted = (state == S_HALT);
    bus.mode   = state;
  end

  // ---------------- load counter ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (bus.prog_en && (state != S_LOAD)) begin
      count_q <= '0;
    end else if (load_ok && (count_q < DEPTH_L)) begin
      count_q <= count_q + 1'b1;
    end
  end

  // ---------------- registered fetch response ----------------
  // fetch_instr/fetch_err hold their last values while no fetch is issued.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      instr_q <= '0;
      err_q   <= 1'b0;
    end else begin
      valid_q <= fetch_go;
      if (fetch_go) begin
        err_q   <= !fetch_in;
        instr_q <= fetch_in ? rd_word[INSTR_W-1:0] : '0;
      end
    end
  end

`ifdef IMEM_PARITY_EN
  logic par_err_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           par_err_q <= 1'b0;
    else if (fetch_go) par_err_q <= fetch_in && rd_par_bad;
  end
  assign bus.par_err = par_err_q;
`endif

  assign bus.load_count  = count_q;
  assign bus.fetch_valid = valid_q;
  assign bus.fetch_instr = instr_q;
  assign bus.fetch_err   = err_q;

endmodule

// File: tb/tb_imem_prog_fetch.sv
module tb_imem_prog_fetch;
  localparam int AW = 8;
  localparam int IW = 16;
  localparam int DP = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  imem_prog_fetch_if #(.ADDR_W(AW), .INSTR_W(IW)) bus ();

  imem_prog_fetch #(
    .ADDR_W(AW), .INSTR_W(IW), .DEPTH(DP), .HALT_OPCODE(4'hF)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: mode 0 LOAD, 1 RUN, 2 HALT
  int          m_mode;
  int          m_cnt;
  bit          m_valid;
  logic [15:0] m_instr;
  bit          m_err;
  bit          m_par;
  logic [15:0] m_mem [DP];
  bit          m_bad [DP];
  bit          inj = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_cnt = 0; m_valid = 0; m_instr = '0; m_err = 0; m_par = 0;
  endtask

  task automatic check_all();
    chk("fetch_valid", 32'(bus.fetch_valid), 32'(m_valid));
    chk("fetch_instr", 32'(bus.fetch_instr), 32'(m_instr));
    chk("fetch_err",   32'(bus.fetch_err),   32'(m_err));
    chk("halted",      32'(bus.halted),      32'(m_mode == 2));
    chk("mode",        32'(bus.mode),        32'(m_mode));
    chk("load_count",  32'(bus.load_count),  32'(m_cnt));
`ifdef IMEM_PARITY_EN
    chk("par_err",     32'(bus.par_err),     32'(m_par));
`endif
  endtask

  // One clock cycle: drive inputs, advance the model at the edge, compare after it.
  task automatic step(input bit pe, input bit st, input bit lv, input int la,
                      input logic [15:0] ld, input bit fr, input int fa);
    bus.prog_en    = pe;
    bus.start      = st;
    bus.load_valid = lv;
    bus.load_addr  = AW'(la);
    bus.load_data  = ld;
    bus.fetch_req  = fr;
    bus.fetch_addr = AW'(fa);
`ifdef IMEM_PARITY_EN
    bus.par_inject = inj;
`endif
    @(posedge clk);
    case (m_mode)
      0: begin
        m_valid = 0;
        if (lv && la < DP) begin
          m_mem[la] = ld;
          m_bad[la] = inj;
          if (m_cnt < DP) m_cnt++;
        end
        if (st) m_mode = 1;
      end
      1: begin
        if (pe) begin
          m_mode = 0; m_cnt = 0; m_valid = 0;
        end else if (fr) begin
          m_valid = 1;
          if (fa >= DP) begin
            m_err = 1; m_instr = '0; m_par = 0;
          end else begin
            m_err = 0; m_instr = m_mem[fa]; m_par = m_bad[fa];
            if (m_instr[15:12] == 4'hF && !m_par) m_mode = 2;
          end
        end else begin
          m_valid = 0;
        end
      end
      default: begin
        m_valid = 0;
        if (pe) begin m_mode = 0; m_cnt = 0; end
      end
    endcase
    #1;
    check_all();
  endtask

  logic [15:0] prog [5];

  initial begin
    prog[0] = 16'h1123; prog[1] = 16'h2114; prog[2] = 16'h6104;
    prog[3] = 16'h7108; prog[4] = 16'hF000;
    for (int i = 0; i < DP; i++) m_bad[i] = 0;
    bus.prog_en = 0; bus.start = 0; bus.load_valid = 0; bus.load_addr = '0;
    bus.load_data = '0; bus.fetch_req = 0; bus.fetch_addr = '0;
`ifdef IMEM_PARITY_EN
    bus.par_inject = 0;
`endif
    model_reset();
    #2;
    check_all();                       // reset state
    rst = 1'b0;

    // Load program, plus an out-of-range write that must not count
    for (int i = 0; i < 5; i++) step(0, 0, 1, i, prog[i], 0, 0);
    step(0, 0, 1, 20, 16'hBEEF, 0, 0);
    chk("tp_count5", 32'(bus.load_count), 32'd5);
    step(0, 1, 0, 0, 0, 1, 0);         // start (fetch_req ignored in LOAD)
    step(0, 0, 1, 1, 16'hAAAA, 0, 0);  // load in RUN ignored
    step(0, 0, 0, 0, 0, 1, 20);        // out-of-range fetch
    chk("tp_oor_err", 32'(bus.fetch_err), 32'd1);
    step(0, 0, 0, 0, 0, 1, 1);
    chk("tp_addr1", 32'(bus.fetch_instr), 32'h2114);
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 0, 0, 0, 1, i);
      chk("tp_seq", 32'(bus.fetch_instr), 32'(prog[i]));
    end
    chk("tp_halted", 32'(bus.halted), 32'd1);
    step(0, 0, 0, 0, 0, 1, 0);         // discarded request
    chk("tp_no_valid", 32'(bus.fetch_valid), 32'd0);
    step(0, 1, 1, 2, 16'h5555, 1, 0);  // start/load/fetch ignored in HALT
    step(1, 1, 0, 0, 0, 0, 0);         // prog_en wins over start
    chk("tp_mode_load", 32'(bus.mode), 32'd0);
    step(0, 1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 0);
    chk("tp_retained", 32'(bus.fetch_instr), 32'h1123);

    // Reset with a fetch in flight
    bus.fetch_req = 1; bus.fetch_addr = 8'd2;
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check_all();
    @(posedge clk);
    #1;
    check_all();
    rst = 1'b0;
    step(0, 1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 2);
    chk("tp_after_rst", 32'(bus.fetch_instr), 32'h6104);

`ifdef IMEM_PARITY_EN
    step(1, 0, 0, 0, 0, 0, 0);
    inj = 1;
    step(0, 0, 1, 3, 16'hF000, 0, 0);
    inj = 0;
    step(0, 1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 3);
    chk("tp_par_err", 32'(bus.par_err), 32'd1);
    chk("tp_par_nohalt", 32'(bus.halted), 32'd0);
    step(0, 0, 0, 0, 0, 1, 0);
    chk("tp_par_ok", 32'(bus.par_err), 32'd0);
`endif

    // Randomized phase: full reload so every model word is known, then mixed traffic
    step(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < DP; i++) step(0, 0, 1, i, 16'($urandom), 0, 0);
    step(0, 1, 0, 0, 0, 0, 0);
    for (int c = 0; c < 800; c++) begin
`ifdef IMEM_PARITY_EN
      inj = ($urandom_range(0, 7) == 0);
`endif
      step($urandom_range(0, 39) == 0, $urandom_range(0, 9) == 0,
           $urandom_range(0, 1) == 1, int'($urandom_range(0, 19)), 16'($urandom),
           $urandom_range(0, 3) != 0, int'($urandom_range(0, 19)));
      // keep the run from idling in HALT too long
      if (m_mode == 2 && $urandom_range(0, 3) == 0) step(1, 0, 0, 0, 0, 0, 0);
      if (m_mode == 0 && $urandom_range(0, 5) == 0) step(0, 1, 0, 0, 0, 0, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
